// File: rtl/hazard_pipe_regs.sv
// PC, IF/ID and ID/EX pipeline registers of the 5-stage RV32I core, applying hazard stalls/flushes.
// Optional stall/flush performance counters are built when PERF_CNT_EN is defined.
module hazard_pipe_regs #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CTRL_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              FlushE,
    input  logic              PCSrcE,
    input  logic [31:0]       PCTargetE,
    input  logic [31:0]       InstrF,
    output logic [31:0]       PCF,
    output logic [31:0]       InstrD,
    output logic [31:0]       PCD,
    output logic [31:0]       PCPlus4D,
    output logic              ValidD,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [31:0]       RD1D,
    input  logic [31:0]       RD2D,
    input  logic [31:0]       ImmExtD,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [31:0]       RD1E,
    output logic [31:0]       RD2E,
    output logic [31:0]       ImmExtE,
    output logic [31:0]       PCE,
    output logic [31:0]       PCPlus4E,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic              ValidE,
    output logic [31:0]       StallCnt,
    output logic [31:0]       FlushCnt
);

    logic [31:0] pcPlus4F;

    assign pcPlus4F = PCF + 32'd4;

    // A resolved redirect beats StallF so a taken branch is never lost behind a load-use hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            PCF <= RESET_PC;
        end else if (PCSrcE) begin
            PCF <= PCTargetE;
        end else if (!StallF) begin
            PCF <= pcPlus4F;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= pcPlus4F;
            ValidD   <= 1'b1;
        end
    end

    // A bubble clears the whole control bundle, so it can never write registers or memory.
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            CtrlE    <= '0;
            RD1E     <= 32'd0;
            RD2E     <= 32'd0;
            ImmExtE  <= 32'd0;
            PCE      <= 32'd0;
            PCPlus4E <= 32'd0;
            Rs1E     <= 5'd0;
            Rs2E     <= 5'd0;
            RdE      <= 5'd0;
            ValidE   <= 1'b0;
        end else begin
            CtrlE    <= CtrlD;
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            ImmExtE  <= ImmExtD;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            Rs1E     <= InstrD[19:15];
            Rs2E     <= InstrD[24:20];
            RdE      <= InstrD[11:7];
            ValidE   <= ValidD;
        end
    end

`ifdef PERF_CNT_EN
    // A stall that is overridden by a flush in decode is not counted as a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCnt <= 32'd0;
            FlushCnt <= 32'd0;
        end else begin
            if (StallD && !FlushD) StallCnt <= StallCnt + 32'd1;
            if (FlushE)            FlushCnt <= FlushCnt + 32'd1;
        end
    end
`else
    assign StallCnt = 32'd0;
    assign FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_pipe_regs.sv
// Directed bench for hazard_pipe_regs: free-run, load-use stall, branch flush, combined hazards,
// reset during stall and PC wrap.
module tb_hazard_pipe_regs;

    localparam int CTRL_W = 10;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] LW_X5  = 32'h0000_A283;  // lw  x5, 0(x1)
    localparam logic [31:0] ADD_X6 = 32'h0012_8333;  // add x6, x5, x1

    logic              clk = 1'b0;
    logic              reset, StallF, StallD, FlushD, FlushE, PCSrcE;
    logic [31:0]       PCTargetE, InstrF;
    logic [31:0]       PCF, InstrD, PCD, PCPlus4D;
    logic              ValidD, ValidE;
    logic [CTRL_W-1:0] CtrlD, CtrlE;
    logic [31:0]       RD1D, RD2D, ImmExtD;
    logic [31:0]       RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]        Rs1E, Rs2E, RdE;
    logic [31:0]       StallCnt, FlushCnt;

    int passed = 0;
    int total  = 0;
    logic [31:0] expStall, expFlush;

    always #5 clk = ~clk;

    hazard_pipe_regs #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .FlushE(FlushE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic haz(input logic sf, input logic sd, input logic fd, input logic fe,
                       input logic pcs, input logic [31:0] tgt);
        StallF = sf; StallD = sd; FlushD = fd; FlushE = fe; PCSrcE = pcs; PCTargetE = tgt;
    endtask

    function automatic logic [31:0] cnt(input logic [31:0] v);
`ifdef PERF_CNT_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    initial begin
        reset = 1'b1; InstrF = 32'h0; CtrlD = '0; RD1D = 0; RD2D = 0; ImmExtD = 0;
        haz(0, 0, 0, 0, 0, 32'h0);
        step();
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_instrd", InstrD, NOP);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_validd", {31'd0, ValidD}, 32'd0);
        chk("rst_valide", {31'd0, ValidE}, 32'd0);
        chk("rst_ctrle", {22'd0, CtrlE}, 32'd0);
        chk("rst_stallcnt", StallCnt, 32'd0);
        chk("rst_flushcnt", FlushCnt, 32'd0);

        // 1: free-running fetch
        reset = 1'b0; InstrF = 32'hAAAA_AAAA;
        step();
        chk("t1_pcf1", PCF, 32'h4);
        chk("t1_instrd1", InstrD, 32'hAAAA_AAAA);
        chk("t1_pcplus4d1", PCPlus4D, 32'h4);
        chk("t1_validd1", {31'd0, ValidD}, 32'd1);
        chk("t1_valide1", {31'd0, ValidE}, 32'd0);
        InstrF = 32'hBBBB_BBBB;
        step();
        chk("t1_pcf2", PCF, 32'h8);
        chk("t1_instrd2", InstrD, 32'hBBBB_BBBB);
        chk("t1_pcd2", PCD, 32'h4);
        chk("t1_valide2", {31'd0, ValidE}, 32'd1);
        InstrF = 32'hCCCC_CCCC;
        step();
        chk("t1_pcf3", PCF, 32'hC);
        InstrF = 32'hDDDD_DDDD;
        step();
        chk("t1_pcf4", PCF, 32'h10);
        chk("t1_instrd4", InstrD, 32'hDDDD_DDDD);
        chk("t1_pce4", PCE, 32'h8);

        // 2: load-use stall
        InstrF = LW_X5;
        step();
        InstrF = ADD_X6; CtrlD = 10'h2A5; RD1D = 32'h1234_5678; ImmExtD = 32'h0000_0040;
        step();
        chk("t2_pcf_pre", PCF, 32'h18);
        chk("t2_rde_lw", {27'd0, RdE}, 32'd5);
        chk("t2_ctrle_lw", {22'd0, CtrlE}, 32'h2A5);
        chk("t2_rd1e_lw", RD1E, 32'h1234_5678);
        chk("t2_instrd_add", InstrD, ADD_X6);
        haz(1, 1, 0, 1, 0, 32'h0); InstrF = 32'h3333_3333; CtrlD = 10'h155;
        step();
        chk("t2_pcf_hold", PCF, 32'h18);
        chk("t2_instrd_hold", InstrD, ADD_X6);
        chk("t2_pcd_hold", PCD, 32'h14);
        chk("t2_ctrle_bub", {22'd0, CtrlE}, 32'd0);
        chk("t2_rde_bub", {27'd0, RdE}, 32'd0);
        chk("t2_rd1e_bub", RD1E, 32'd0);
        chk("t2_valide_bub", {31'd0, ValidE}, 32'd0);
        chk("t2_stallcnt", StallCnt, cnt(32'd1));
        chk("t2_flushcnt", FlushCnt, cnt(32'd1));
        haz(0, 0, 0, 0, 0, 32'h0);
        step();
        chk("t2_pcf_go", PCF, 32'h1C);
        chk("t2_rde_add", {27'd0, RdE}, 32'd6);
        chk("t2_rs1e_add", {27'd0, Rs1E}, 32'd5);
        chk("t2_rs2e_add", {27'd0, Rs2E}, 32'd1);
        chk("t2_ctrle_add", {22'd0, CtrlE}, 32'h155);
        chk("t2_pce_add", PCE, 32'h14);
        chk("t2_pcplus4e_add", PCPlus4E, 32'h18);
        chk("t2_valide_add", {31'd0, ValidE}, 32'd1);
        chk("t2_instrd_next", InstrD, 32'h3333_3333);

        // 3: taken branch
        haz(0, 0, 1, 1, 1, 32'h0000_0100);
        step();
        chk("t3_pcf", PCF, 32'h100);
        chk("t3_instrd", InstrD, NOP);
        chk("t3_pcd", PCD, 32'h0);
        chk("t3_validd", {31'd0, ValidD}, 32'd0);
        chk("t3_valide", {31'd0, ValidE}, 32'd0);
        chk("t3_ctrle", {22'd0, CtrlE}, 32'd0);
        chk("t3_flushcnt", FlushCnt, cnt(32'd2));
        haz(0, 0, 0, 0, 0, 32'h0); InstrF = 32'h4444_4444;
        step();
        chk("t3_pcf_after", PCF, 32'h104);
        chk("t3_validd_after", {31'd0, ValidD}, 32'd1);
        chk("t3_valide_after", {31'd0, ValidE}, 32'd0);

        // 4: all hazards together, first with redirect then without
        haz(1, 1, 1, 1, 1, 32'h0000_0200);
        step();
        chk("t4_pcf_redir", PCF, 32'h200);
        chk("t4_instrd", InstrD, NOP);
        chk("t4_validd", {31'd0, ValidD}, 32'd0);
        chk("t4_valide", {31'd0, ValidE}, 32'd0);
        chk("t4_ctrle", {22'd0, CtrlE}, 32'd0);
        chk("t4_stallcnt", StallCnt, cnt(32'd1));
        chk("t4_flushcnt", FlushCnt, cnt(32'd3));
        haz(1, 1, 1, 1, 0, 32'h0000_0300);
        step();
        chk("t4_pcf_hold", PCF, 32'h200);
        chk("t4_flushcnt2", FlushCnt, cnt(32'd4));

        // 5: reset during a stall
        haz(0, 0, 0, 0, 1, 32'h0000_0040); InstrF = 32'h5555_5555;
        step();
        chk("t5_pcf_pre", PCF, 32'h40);
        chk("t5_validd_pre", {31'd0, ValidD}, 32'd1);
        haz(0, 1, 0, 0, 0, 32'h0); reset = 1'b1;
        step();
        chk("t5_pcf", PCF, 32'h0);
        chk("t5_instrd", InstrD, NOP);
        chk("t5_validd", {31'd0, ValidD}, 32'd0);
        chk("t5_valide", {31'd0, ValidE}, 32'd0);
        chk("t5_stallcnt", StallCnt, 32'd0);
        chk("t5_flushcnt", FlushCnt, 32'd0);
        reset = 1'b0;

        // 6: PC wrap
        haz(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        step();
        chk("t6_pcf_pre", PCF, 32'hFFFF_FFFC);
        haz(0, 0, 0, 0, 0, 32'h0);
        step();
        chk("t6_pcf_wrap", PCF, 32'h0);
        chk("t6_pcd", PCD, 32'hFFFF_FFFC);
        chk("t6_pcplus4d", PCPlus4D, 32'h0);

        expStall = StallCnt; expFlush = FlushCnt;
        chk("t6_stallcnt", expStall, 32'd0);
        chk("t6_flushcnt", expFlush, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
